// File: rtl/stepper_pkg.sv
// Purpose: shared types and constants for the double-step stepper sequencer.
// Latency: n/a (types, constants and a pure lookup function only).
// Backpressure: n/a.
package stepper_pkg;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } seqState_t;

  // Command direction encoding: forward advances the electrical phase.
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Two-phase-on coil patterns {D,C,B,A}, indexed by electrical phase.
  localparam logic [3:0] DOUBLE_STEP_PATTERN [0:3] = '{
    4'b0011,  // phase 0: A+B
    4'b0110,  // phase 1: B+C
    4'b1100,  // phase 2: C+D
    4'b1001   // phase 3: D+A
  };

  function automatic logic [3:0] coilPattern(input logic [1:0] ph);
    return DOUBLE_STEP_PATTERN[ph];
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Purpose: synchronise an asynchronous level into clk and flag its rising edges.
// Latency: input rise -> rise pulse visible after SYNC_STAGES clk edges; pulse lasts one cycle.
// Backpressure: none; every synchronised rising edge produces exactly one pulse.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high; clears the chain so no edge is seen at release
//   asyncIn  level from another clock domain (treated as data)
//   rise     one-cycle pulse on each synchronised 0->1 transition
module sync_rise_detect
  import stepper_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic asyncIn,
  output logic rise
);

  logic [SYNC_STAGES-1:0] syncChain;
  logic                   syncOutD;

  always_ff @(posedge clk) begin
    if (reset) begin
      syncChain <= '0;
      syncOutD  <= 1'b0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], asyncIn};
      syncOutD  <= syncChain[SYNC_STAGES-1];
    end
  end

  // Edge detect on the synchronised level; both operands are flops, so the
  // pulse is glitch-free and can feed the sequencer FSM directly.
  assign rise = syncChain[SYNC_STAGES-1] & ~syncOutD;

endmodule

// File: rtl/stepper_double_step_sequencer.sv
// Purpose: drive a 28BYJ-48 unipolar stepper in two-phase-on sequence from a slow divided step clock.
// Latency: step_clk_in rise -> coils/phase update after SYNC_STAGES+1 clk edges; cmd_steps==0 -> done 2 cycles after accept.
// Backpressure: cmd_ready is low during warm-up, a move and its completion cycle; commands are taken only in IDLE.
//
// Ports:
//   clk          50 MHz system clock (the only clock in this block)
//   reset        synchronous, active-high
//   step_clk_in  divided step clock, asynchronous; sampled as data
//   cmd_valid    command request
//   cmd_ready    command can be accepted this cycle
//   cmd_dir      1 = forward (phase+1), 0 = reverse (phase-1)
//   cmd_steps    number of steps to execute
//   abort        terminate the move in progress (ignored outside RUN)
//   coils        coil drive {D,C,B,A}, 1 = energised
//   phase        current electrical phase (persists across moves)
//   steps_left   steps remaining in the current/last move
//   busy         move in progress
//   done         one-cycle pulse, move finished normally
//   aborted      one-cycle pulse, move terminated by abort
module stepper_double_step_sequencer
  import stepper_pkg::*;
#(
  parameter int STEP_CNT_W  = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit HOLD_TORQUE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_clk_in,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [STEP_CNT_W-1:0] cmd_steps,
  input  logic                  abort,
  output logic [3:0]            coils,
  output logic [1:0]            phase,
  output logic [STEP_CNT_W-1:0] steps_left,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  // Warm-up lasts SYNC_STAGES+1 cycles: long enough for a step clock that is
  // already high at reset release to flush through the synchroniser while
  // commands are still refused, so it never turns into a step.
  localparam int              WARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);

  seqState_t               state, stateNext;
  logic [WARM_W-1:0]       warmCnt, warmCntNext;
  logic [1:0]              phaseNext;
  logic [STEP_CNT_W-1:0]   stepsLeftNext;
  logic                    dirLatched, dirNext;
  logic                    abortEvent;
  logic [3:0]              coilsNext;
  logic                    stepRise;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) uSyncRise (
    .clk     (clk),
    .reset   (reset),
    .asyncIn (step_clk_in),
    .rise    (stepRise)
  );

  // Next-state, phase counter and step down-counter.
  always_comb begin
    stateNext     = state;
    warmCntNext   = warmCnt;
    phaseNext     = phase;
    stepsLeftNext = steps_left;
    dirNext       = dirLatched;
    abortEvent    = 1'b0;

    case (state)
      WARMUP: begin
        if (warmCnt == WARM_LAST) begin
          stateNext = IDLE;
        end else begin
          warmCntNext = warmCnt + WARM_W'(1);
        end
      end

      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          dirNext       = cmd_dir;
          stepsLeftNext = cmd_steps;
          // A zero-length move still reports completion, without moving.
          stateNext     = (cmd_steps == '0) ? FINISH : RUN;
        end
      end

      RUN: begin
        // Abort has priority over a coincident step pulse, including the last one.
        if (abort) begin
          stateNext  = IDLE;
          abortEvent = 1'b1;
        end else if (stepRise) begin
          phaseNext     = (dirLatched == DIR_FWD) ? phase + 2'd1 : phase - 2'd1;
          stepsLeftNext = steps_left - STEP_CNT_W'(1);
          if (steps_left == STEP_CNT_W'(1)) begin
            stateNext = FINISH;
          end
        end
      end

      FINISH: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Coil decode. The final step of a move is shown on the coils for the
  // FINISH cycle; a zero-length move passes through FINISH without touching them.
  always_comb begin
    coilsNext = 4'b0000;
    if (stateNext == RUN || (state == RUN && stateNext == FINISH)) begin
      coilsNext = coilPattern(phaseNext);
    end else if (stateNext == FINISH) begin
      coilsNext = coils;
    end else if (HOLD_TORQUE && stateNext == IDLE) begin
      coilsNext = coilPattern(phaseNext);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WARMUP;
      warmCnt    <= '0;
      phase      <= 2'd0;
      steps_left <= '0;
      dirLatched <= DIR_FWD;
      coils      <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      cmd_ready  <= 1'b0;
    end else begin
      state      <= stateNext;
      warmCnt    <= warmCntNext;
      phase      <= phaseNext;
      steps_left <= stepsLeftNext;
      dirLatched <= dirNext;
      coils      <= coilsNext;
      busy       <= (stateNext == RUN);
      cmd_ready  <= (stateNext == IDLE);
      // done is registered off FINISH itself, so it lands the cycle after FINISH is entered.
      done       <= (state == FINISH);
      aborted    <= abortEvent;
    end
  end

endmodule

// File: tb/tb_stepper_double_step_sequencer.sv
module tb_stepper_double_step_sequencer;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         step_clk_in;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_dir;
  logic [W-1:0] cmd_steps;
  logic         abort;
  logic [3:0]   coils;
  logic [1:0]   phase;
  logic [W-1:0] steps_left;
  logic         busy;
  logic         done;
  logic         aborted;

  stepper_double_step_sequencer #(
    .STEP_CNT_W  (W),
    .SYNC_STAGES (2),
    .HOLD_TORQUE (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .step_clk_in (step_clk_in),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dir     (cmd_dir),
    .cmd_steps   (cmd_steps),
    .abort       (abort),
    .coils       (coils),
    .phase       (phase),
    .steps_left  (steps_left),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Pulse/level counters sampled on the falling edge.
  int doneCnt    = 0;
  int abortedCnt = 0;
  int busyCnt    = 0;
  always @(negedge clk) begin
    if (done)    doneCnt++;
    if (aborted) abortedCnt++;
    if (busy)    busyCnt++;
  end

  // Reference model: motor electrical position 0..3.
  int mPhase = 0;

  logic [3:0]   preCoils, postCoils;
  logic [1:0]   prePhase, postPhase;
  logic [W-1:0] postSteps;
  logic         postAborted;

  function automatic logic [3:0] refPattern(input int ph);
    case (ph)
      0:       return 4'b0011;
      1:       return 4'b0110;
      2:       return 4'b1100;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic int stepModel(input int ph, input logic fwd);
    return fwd ? (ph + 1) % 4 : (ph + 3) % 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command and wait (bounded) for the handshake edge.
  task automatic issueCmd(input logic dir, input int n, output bit ok);
    ok        = 1'b0;
    cmd_dir   = dir;
    cmd_steps = W'(n);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  // One step-clock period: high 3 edges, low 4. Observations are taken just
  // before and just after the third edge, where the step is due.
  task automatic riseEdge(input bit withAbort);
    step_clk_in = 1'b1;
    tick();
    tick();
    preCoils    = coils;
    prePhase    = phase;
    abort       = withAbort;
    tick();
    abort       = 1'b0;
    postCoils   = coils;
    postPhase   = phase;
    postSteps   = steps_left;
    postAborted = aborted;
    step_clk_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; step_clk_in = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_steps = '0; abort = 1'b0;
    repeat (5) tick();
    checks++;
    if (coils !== 4'b0000 || phase !== 2'd0 || steps_left !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || aborted !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: coils=%b phase=%0d steps_left=%0d busy=%b done=%b aborted=%b rdy=%b, want all zero",
               coils, phase, steps_left, busy, done, aborted, cmd_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL warmup_ready cycle %0d: got %b want 0", i, cmd_ready);
      end
      tick();
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_ready: got %b want 1", cmd_ready);
    end
    repeat (3) tick();
    checks++;
    if (phase !== 2'd0 || coils !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL spurious_edge: phase=%0d coils=%b busy=%b want 0/0000/0", phase, coils, busy);
    end
    step_clk_in = 1'b0;
    repeat (4) tick();
    mPhase = 0;
  endtask

  // Runs a full move, checking each step against the model.
  task automatic test_move(input string name, input logic dir, input int n);
    bit ok;
    int d0;
    d0 = doneCnt;
    issueCmd(dir, n, ok);
    checks++;
    if (!ok || busy !== 1'b1 || coils !== refPattern(mPhase)) begin
      fails++;
      $display("FAIL %s_start: accepted=%b busy=%b coils=%b want 1/1/%b", name, ok, busy, coils, refPattern(mPhase));
    end
    for (int s = 0; s < n; s++) begin
      riseEdge(1'b0);
      checks++;
      if (preCoils !== refPattern(mPhase)) begin
        fails++;
        $display("FAIL %s_latency step %0d: coils changed early to %b want %b", name, s, preCoils, refPattern(mPhase));
      end
      mPhase = stepModel(mPhase, dir);
      checks++;
      if (postCoils !== refPattern(mPhase) || postPhase !== 2'(mPhase) || postSteps !== W'(n - 1 - s)) begin
        fails++;
        $display("FAIL %s_step %0d: coils=%b phase=%0d left=%0d want %b/%0d/%0d",
                 name, s, postCoils, postPhase, postSteps, refPattern(mPhase), mPhase, n - 1 - s);
      end
    end
    checks++;
    if (doneCnt - d0 !== 1 || busy !== 1'b0 || steps_left !== '0 || coils !== 4'b0000 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_end: done pulses=%0d busy=%b left=%0d coils=%b rdy=%b want 1/0/0/0000/1",
               name, doneCnt - d0, busy, steps_left, coils, cmd_ready);
    end
  endtask

  task automatic test_fwd_five();
    test_move("fwd5", 1'b1, 5);
    checks++;
    if (phase !== 2'd1) begin
      fails++;
      $display("FAIL fwd5_phase: got %0d want 1", phase);
    end
  endtask

  task automatic test_rev_three();
    test_move("rev3", 1'b0, 3);
    checks++;
    if (phase !== 2'd2) begin
      fails++;
      $display("FAIL rev3_phase: got %0d want 2", phase);
    end
  endtask

  task automatic test_zero_steps();
    bit ok;
    int d0, b0;
    d0 = doneCnt; b0 = busyCnt;
    issueCmd(1'b1, 0, ok);
    checks++;
    if (!ok || done !== 1'b0 || cmd_ready !== 1'b0 || coils !== 4'b0000) begin
      fails++;
      $display("FAIL zero_accept: accepted=%b done=%b rdy=%b coils=%b want 1/0/0/0000", ok, done, cmd_ready, coils);
    end
    tick();
    checks++;
    if (done !== 1'b1 || coils !== 4'b0000) begin
      fails++;
      $display("FAIL zero_done: done=%b coils=%b want 1/0000", done, coils);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busyCnt !== b0 || doneCnt - d0 !== 1 || phase !== 2'(mPhase)) begin
      fails++;
      $display("FAIL zero_after: done=%b busy cycles=%0d done pulses=%0d phase=%0d want 0/0/1/%0d",
               done, busyCnt - b0, doneCnt - d0, phase, mPhase);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int d0, a0;
    d0 = doneCnt; a0 = abortedCnt;
    issueCmd(1'b1, 10, ok);
    for (int s = 0; s < 2; s++) begin
      riseEdge(1'b0);
      mPhase = stepModel(mPhase, 1'b1);
    end
    riseEdge(1'b1);
    checks++;
    if (!ok || postPhase !== prePhase || postPhase !== 2'(mPhase) || postAborted !== 1'b1 || postSteps !== W'(8)) begin
      fails++;
      $display("FAIL abort_edge: accepted=%b phase %0d->%0d aborted=%b left=%0d want no step, phase %0d, 1, 8",
               ok, prePhase, postPhase, postAborted, postSteps, mPhase);
    end
    checks++;
    if (doneCnt !== d0 || abortedCnt - a0 !== 1 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        coils !== 4'b0000 || steps_left !== W'(8)) begin
      fails++;
      $display("FAIL abort_after: done pulses=%0d aborted pulses=%0d busy=%b rdy=%b coils=%b left=%0d want 0/1/0/1/0000/8",
               doneCnt - d0, abortedCnt - a0, busy, cmd_ready, coils, steps_left);
    end
    a0 = abortedCnt;
    abort = 1'b1;
    repeat (2) tick();
    abort = 1'b0;
    tick();
    checks++;
    if (abortedCnt !== a0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle: aborted pulses=%0d rdy=%b want 0/1", abortedCnt - a0, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int d0, a0;
    issueCmd(1'b1, 6, ok);
    riseEdge(1'b0);
    riseEdge(1'b0);
    checks++;
    if (!ok || steps_left !== W'(4) || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrun_pre: accepted=%b left=%0d busy=%b want 1/4/1", ok, steps_left, busy);
    end
    d0 = doneCnt; a0 = abortedCnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (coils !== 4'b0000 || phase !== 2'd0 || busy !== 1'b0 || steps_left !== '0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: coils=%b phase=%0d busy=%b left=%0d rdy=%b want 0000/0/0/0/0",
               coils, phase, busy, steps_left, cmd_ready);
    end
    mPhase = 0;
    riseEdge(1'b0);
    riseEdge(1'b0);
    checks++;
    if (phase !== 2'd0 || coils !== 4'b0000 || doneCnt !== d0 || abortedCnt !== a0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrun_ignore: phase=%0d coils=%b done pulses=%0d aborted pulses=%0d busy=%b want 0/0000/0/0/0",
               phase, coils, doneCnt - d0, abortedCnt - a0, busy);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      logic dir;
      int   n;
      dir = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 6));
      test_move("rand", dir, n);
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fwd_five();
    test_rev_three();
    test_zero_steps();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
